// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and helpers for the scan sequencer.
//               - scan_state_e   : sequencer FSM states
//               - prescaler_width: dwell counter width, max(1, clog2(DIV))
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // A one-cycle dwell still needs a 1-bit counter so the port stays legal.
    function automatic int prescaler_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Dwell counter. Counts 0..DIV-1 and pulses tick while the
//               count equals DIV-1, then wraps to 0. A synchronous clear
//               holds the count at 0.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               clr   - synchronous clear (count forced to 0 next edge)
//               tick  - high while count == DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    import scan_pkg::*;

    localparam int                 c_CNT_W = prescaler_width(DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Registered index sequencer for multiplexed digit/row scanning.
//               Holds each index for DIV cycles and steps 0..2**S-1, either
//               continuously or for one sweep. Flags wrap-around and sweep
//               completion. All outputs are registered.
//               Build option: define SCAN_BLANK_EN to insert one blanking
//               cycle (idx_vld low, idx held) after every dwell.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               en      - run enable, low forces IDLE
//               start   - request to begin scanning (IDLE only)
//               single  - 1: one sweep, 0: continuous (sampled with start)
//               idx     - current index (to decoder select)
//               idx_vld - idx valid, decoder may drive
//               wrap    - pulse on the cycle idx leaves 2**S-1
//               done    - pulse when a single sweep ends
//               busy    - not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int S   = 2,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         start,
    input  logic         single,
    output logic [S-1:0] idx,
    output logic         idx_vld,
    output logic         wrap,
    output logic         done,
    output logic         busy
);
    import scan_pkg::*;

    localparam logic [S-1:0] c_IDX_MAX = '1;

    scan_state_e  state_q, state_d;
    logic [S-1:0] idx_q, idx_d;
    logic         vld_q, vld_d;
    logic         mode_q, mode_d;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic         tick;
    logic         step;

    // The counter only runs in RUN; every entry into RUN comes from a state
    // where it was held clear, so each dwell starts at count 0.
    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_RUN),
        .tick  (tick)
    );

    // Index advance point: end of dwell, or end of the blanking cycle.
`ifdef SCAN_BLANK_EN
    assign step = (state_q == ST_BLANK);
`else
    assign step = (state_q == ST_RUN) && tick;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            vld_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            // No restart in the cycle done is still showing.
            if (start && !done_q) begin
                state_d = ST_RUN;
                idx_d   = '0;
                vld_d   = 1'b1;
                mode_d  = single;
            end
`ifdef SCAN_BLANK_EN
        end else if ((state_q == ST_RUN) && tick) begin
            state_d = ST_BLANK;
            vld_d   = 1'b0;
`endif
        end else if (step) begin
            if (idx_q != c_IDX_MAX) begin
                state_d = ST_RUN;
                idx_d   = idx_q + 1'b1;
                vld_d   = 1'b1;
            end else if (!mode_q) begin
                state_d = ST_RUN;
                idx_d   = '0;
                vld_d   = 1'b1;
                wrap_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
                vld_d   = 1'b0;
                wrap_d  = 1'b1;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign idx     = idx_q;
    assign idx_vld = vld_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Scoreboard bench for scan_sequencer. Two instances: DIV=4
//               (main) and DIV=1. Expected outputs per cycle come from the
//               closed-form scan pattern and are queued; a monitor pops and
//               compares at the falling edge (or on demand for the
//               asynchronous reset check).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
    localparam int BLK = 1;
`else
    localparam int BLK = 0;
`endif
    localparam int P4 = 4 + BLK;   // cycles per index, DIV=4
    localparam int P1 = 1 + BLK;   // cycles per index, DIV=1

    typedef struct {
        bit         sel;
        logic [5:0] exp;   // {idx[1:0], idx_vld, wrap, done, busy}
        string      tag;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0, start = 1'b0, single = 1'b0;
    logic en1 = 1'b0, start1 = 1'b0, single1 = 1'b0;

    logic [1:0] idx0, idx1;
    logic vld0, wrap0, done0, busy0;
    logic vld1, wrap1, done1, busy1;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    event chk_now;

    always #5 clk = ~clk;

    scan_sequencer #(.S(2), .DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .single(single),
        .idx(idx0), .idx_vld(vld0), .wrap(wrap0), .done(done0), .busy(busy0)
    );

    scan_sequencer #(.S(2), .DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .start(start1), .single(single1),
        .idx(idx1), .idx_vld(vld1), .wrap(wrap1), .done(done1), .busy(busy1)
    );

    // Monitor
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = e.sel ? {idx1, vld1, wrap1, done1, busy1}
                            : {idx0, vld0, wrap0, done0, busy0};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s c=%0d {idx,vld,wrap,done,busy} got=%b exp=%b",
                             e.tag, e.cyc, act, e.exp);
                end
            end
        end
    end

    task automatic push_exp(input bit sel, input int i, input logic v, input logic w,
                            input logic d, input logic b, input string tag, input int c);
        exp_t e;
        logic [1:0] i2;
        i2 = i[1:0];
        e.sel = sel;
        e.exp = {i2, v, w, d, b};
        e.tag = tag;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Advance one clock and queue the outputs expected after that edge.
    task automatic tick_exp(input bit sel, input int i, input logic v, input logic w,
                            input logic d, input logic b, input string tag, input int c);
        @(posedge clk);
        push_exp(sel, i, v, w, d, b, tag, c);
        #1;
    endtask

    // Expected scan pattern, c = cycles since the accepting edge (c=0 first).
    task automatic scan_exp(input bit sel, input int p, input int div, input bit sgl,
                            input int c, input string tag);
        if (sgl && c == 4 * p)
            tick_exp(sel, 0, 1'b0, 1'b1, 1'b1, 1'b0, tag, c);
        else if (sgl && c > 4 * p)
            tick_exp(sel, 0, 1'b0, 1'b0, 1'b0, 1'b0, tag, c);
        else
            tick_exp(sel, (c / p) % 4, ((c % p) < div), (c > 0 && (c % (4 * p)) == 0),
                     1'b0, 1'b1, tag, c);
    endtask

    task automatic idle_exp(input bit sel, input int n, input string tag);
        for (int k = 0; k < n; k++) tick_exp(sel, 0, 1'b0, 1'b0, 1'b0, 1'b0, tag, k);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #2;
        push_exp(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold", 0);
        ->chk_now;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        idle_exp(1'b0, 20, "idle_no_start");

        // Continuous sweep; single toggled mid-run must be ignored
        start = 1'b1; single = 1'b0;
        scan_exp(1'b0, P4, 4, 1'b0, 0, "cont");
        start = 1'b0; single = 1'b1;
        for (int c = 1; c <= 8 * P4 + 3; c++) scan_exp(1'b0, P4, 4, 1'b0, c, "cont");
        en = 1'b0;
        idle_exp(1'b0, 1, "cont_stop");
        en = 1'b1; single = 1'b0;
        idle_exp(1'b0, 1, "cont_idle");

        // Single sweep, start during done ignored, restart after
        start = 1'b1; single = 1'b1;
        scan_exp(1'b0, P4, 4, 1'b1, 0, "single");
        start = 1'b0; single = 1'b0;
        for (int c = 1; c <= 4 * P4; c++) scan_exp(1'b0, P4, 4, 1'b1, c, "single");
        start = 1'b1; single = 1'b1;
        scan_exp(1'b0, P4, 4, 1'b1, 4 * P4 + 1, "start_in_done");
        scan_exp(1'b0, P4, 4, 1'b1, 0, "restart");
        start = 1'b0; single = 1'b0;
        for (int c = 1; c <= 2 * P4 + 1; c++) scan_exp(1'b0, P4, 4, 1'b1, c, "restart");

        // Abort at idx=2 mid-dwell, then start with en low
        en = 1'b0;
        idle_exp(1'b0, 1, "abort");
        start = 1'b1;
        idle_exp(1'b0, 2, "start_en_low");
        start = 1'b0; en = 1'b1;
        idle_exp(1'b0, 2, "after_abort");

        // Asynchronous reset while idx=3
        start = 1'b1; single = 1'b0;
        scan_exp(1'b0, P4, 4, 1'b0, 0, "pre_rst");
        start = 1'b0;
        for (int c = 1; c <= 3 * P4; c++) scan_exp(1'b0, P4, 4, 1'b0, c, "pre_rst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push_exp(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "async_rst", 0);
        ->chk_now;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_exp(1'b0, 3, "post_rst");

        // DIV=1 instance: continuous then single
        en1 = 1'b1; start1 = 1'b1; single1 = 1'b0;
        scan_exp(1'b1, P1, 1, 1'b0, 0, "div1_cont");
        start1 = 1'b0;
        for (int c = 1; c <= 8 * P1 + 1; c++) scan_exp(1'b1, P1, 1, 1'b0, c, "div1_cont");
        en1 = 1'b0;
        idle_exp(1'b1, 1, "div1_stop");
        en1 = 1'b1; start1 = 1'b1; single1 = 1'b1;
        scan_exp(1'b1, P1, 1, 1'b1, 0, "div1_single");
        start1 = 1'b0;
        for (int c = 1; c <= 4 * P1 + 2; c++) scan_exp(1'b1, P1, 1, 1'b1, c, "div1_single");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
